data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported 16-bit data memory between two requesters: port 0 (CPU load/store stage) and port 1 (loader/DMA engine). Each requester uses a req/ack handshake. The arbiter selects one winner, drives the memory's address, write, and read-strobe inputs for one cycle, and returns a registered read result with a one-cycle ack pulse. It sits between the requesters and the data memory and is the only master of the memory port.

---
 rtl/data_mem_arbiter.sv | 94 +++++++++
 tb/tb_data_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port req/ack arbiter that owns the single-ported data memory.
// Each grant takes three cycles: IDLE picks a winner, ACCESS drives the memory, DONE acks.
module data_mem_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic              sel;
    logic              last;
    logic [DATA_W-1:0] rdata;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    always_comb begin
        acc_we    = sel ? p1_we    : p0_we;
        acc_addr  = sel ? p1_addr  : p0_addr;
        acc_wdata = sel ? p1_wdata : p0_wdata;
    end

    // Strobes are gated by reset so a write caught mid-ACCESS never commits.
    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (state == ACCESS && !reset) begin
            mem_access_addr = acc_addr;
            mem_write_data  = acc_wdata;
            mem_write_en    = acc_we;
            mem_read        = ~acc_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sel    <= 1'b0;
            last   <= 1'b1;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            rdata  <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        if (p0_req && p1_req)
                            sel <= (FIXED_PRIO != 0) ? 1'b0 : ~last;
                        else
                            sel <= p1_req;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata  <= acc_we ? '0 : mem_read_data;
                    last   <= sel;
                    p0_ack <= ~sel;
                    p1_ack <= sel;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign p0_rdata = p0_ack ? rdata : '0;
    assign p1_rdata = p1_ack ? rdata : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: per-port request queues, a memory model,
// and a transaction-timeline reference that predicts every output each cycle.
module tb_data_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          req_d [2];
    logic          we_d  [2];
    logic [AW-1:0] addr_d [2];
    logic [DW-1:0] wdata_d [2];

    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_access_addr;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          mem_write_en, mem_read;

    logic [DW-1:0] mem      [256];
    logic [DW-1:0] init_mem [256];
    logic [DW-1:0] ref_mem  [256];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int commits = 0;

    txn_t        txq [2][$];
    int          wait_cnt [2];
    int          start_cyc [2];
    logic [DW-1:0] got_rdata [2][$];
    int          got_lat [2][$];
    int          ord_port [$];
    int          ord_cyc [$];

    // reference: where the single shared transaction slot is in its 3-cycle life
    int          m_phase;
    int          m_sel;
    int          m_last;
    logic [DW-1:0] m_rdata;
    logic        rst_arm = 1'b0;
    int          rst_hits = 0;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(req_d[0]), .p0_we(we_d[0]), .p0_addr(addr_d[0]), .p0_wdata(wdata_d[0]),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(req_d[1]), .p1_we(we_d[1]), .p1_addr(addr_d[1]), .p1_wdata(wdata_d[1]),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_access_addr[8:1]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_en) begin
            mem[mem_access_addr[8:1]] <= mem_write_data;
            commits <= commits + 1;
        end
    end

    // second instance with fixed priority, both ports permanently requesting reads
    logic          fp_reset = 1'b1;
    logic          fp_p0_ack, fp_p1_ack, fp_we, fp_rd;
    logic [DW-1:0] fp_p0_rdata, fp_p1_rdata, fp_wdata, fp_rdata_in;
    logic [AW-1:0] fp_addr;
    int            fp_p0_cnt = 0;
    int            fp_p1_cnt = 0;
    int            fp_last_cyc = -1;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(fp_reset),
        .p0_req(1'b1), .p0_we(1'b0), .p0_addr(16'h0010), .p0_wdata(16'h1111),
        .p0_ack(fp_p0_ack), .p0_rdata(fp_p0_rdata),
        .p1_req(1'b1), .p1_we(1'b0), .p1_addr(16'h0020), .p1_wdata(16'h2222),
        .p1_ack(fp_p1_ack), .p1_rdata(fp_p1_rdata),
        .mem_access_addr(fp_addr), .mem_write_data(fp_wdata),
        .mem_write_en(fp_we), .mem_read(fp_rd), .mem_read_data(fp_rdata_in)
    );
    assign fp_rdata_in = fp_addr ^ 16'h5A5A;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!fp_reset) begin
            if (fp_p1_ack) fp_p1_cnt++;
            if (fp_p0_ack) begin
                if (fp_last_cyc >= 0) check("fp_spacing", 64'(cyc - fp_last_cyc), 64'd3);
                check("fp_rdata", 64'(fp_p0_rdata), 64'(16'h0010 ^ 16'h5A5A));
                fp_last_cyc = cyc;
                fp_p0_cnt++;
            end
        end
    end

    task automatic push(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
        txq[p].push_back(t);
    endtask

    task automatic clear_logs();
        for (int p = 0; p < 2; p++) begin
            got_rdata[p].delete();
            got_lat[p].delete();
        end
        ord_port.delete();
        ord_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req_d[p] = 1'b0;
            txq[p].delete();
            wait_cnt[p] = 0;
        end
        m_phase = 0; m_sel = 0; m_last = 1; m_rdata = '0;
        @(negedge clk);
        check("rst_ack_rdata", 64'({p0_ack, p1_ack, p0_rdata, p1_rdata}), 64'd0);
        check("rst_mem_outs", 64'({mem_access_addr, mem_write_data, mem_write_en, mem_read}), 64'd0);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic step();
        logic          ack_seen [2];
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_we, e_rd, e_ack0, e_ack1;
        @(negedge clk);
        e_addr = '0; e_wd = '0; e_we = 1'b0; e_rd = 1'b0;
        if (m_phase == 1) begin
            e_addr = addr_d[m_sel];
            e_wd   = wdata_d[m_sel];
            e_we   = we_d[m_sel];
            e_rd   = !we_d[m_sel];
        end
        e_ack0 = (m_phase == 2 && m_sel == 0);
        e_ack1 = (m_phase == 2 && m_sel == 1);
        check("p0_ack", 64'(p0_ack), 64'(e_ack0));
        check("p1_ack", 64'(p1_ack), 64'(e_ack1));
        check("p0_rdata", 64'(p0_rdata), e_ack0 ? 64'(m_rdata) : 64'd0);
        check("p1_rdata", 64'(p1_rdata), e_ack1 ? 64'(m_rdata) : 64'd0);
        check("mem_addr", 64'(mem_access_addr), 64'(e_addr));
        check("mem_wdata", 64'(mem_write_data), 64'(e_wd));
        check("mem_we", 64'(mem_write_en), 64'(e_we));
        check("mem_rd", 64'(mem_read), 64'(e_rd));
        ack_seen[0] = p0_ack;
        ack_seen[1] = p1_ack;
        if (reset) reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (ack_seen[p]) begin
                got_rdata[p].push_back(p == 0 ? p0_rdata : p1_rdata);
                got_lat[p].push_back(cyc - start_cyc[p]);
                ord_port.push_back(p);
                ord_cyc.push_back(cyc);
            end
        end
        if (rst_arm && m_phase == 1 && we_d[m_sel]) begin
            reset = 1'b1;
            void'(txq[m_sel].pop_front());
            req_d[m_sel] = 1'b0;
            m_phase = 0; m_sel = 0; m_last = 1;
            rst_arm = 1'b0;
            rst_hits++;
            #1;
            check("rst_we_gated", 64'(mem_write_en), 64'd0);
            check("rst_rd_gated", 64'(mem_read), 64'd0);
            return;
        end
        for (int p = 0; p < 2; p++) begin
            if (req_d[p] && ack_seen[p]) begin
                void'(txq[p].pop_front());
                req_d[p] = 1'b0;
                wait_cnt[p] = 0;
            end
            if (!req_d[p] && txq[p].size() > 0) begin
                if (wait_cnt[p] < txq[p][0].gap) begin
                    wait_cnt[p]++;
                end else begin
                    req_d[p]     = 1'b1;
                    we_d[p]      = txq[p][0].we;
                    addr_d[p]    = txq[p][0].addr;
                    wdata_d[p]   = txq[p][0].wdata;
                    start_cyc[p] = cyc;
                    wait_cnt[p]  = 0;
                end
            end
        end
        case (m_phase)
            0: if (req_d[0] || req_d[1]) begin
                if (req_d[0] && req_d[1]) m_sel = 1 - m_last;
                else m_sel = req_d[1] ? 1 : 0;
                m_phase = 1;
            end
            1: begin
                if (we_d[m_sel]) begin
                    ref_mem[addr_d[m_sel][8:1]] = wdata_d[m_sel];
                    m_rdata = '0;
                end else begin
                    m_rdata = ref_mem[addr_d[m_sel][8:1]];
                end
                m_last = m_sel;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic run_idle(input string tag, input int limit);
        int n = 0;
        while ((txq[0].size() > 0 || txq[1].size() > 0 || m_phase != 0) && n < limit) begin
            step();
            n++;
        end
        check(tag, 64'(txq[0].size() + txq[1].size()), 64'd0);
    endtask

    initial begin
        int c0;
        int bad;
        logic [DW-1:0] v;
        for (int p = 0; p < 2; p++) begin
            req_d[p] = 1'b0; we_d[p] = 1'b0; addr_d[p] = '0; wdata_d[p] = '0;
            wait_cnt[p] = 0; start_cyc[p] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom) | 16'h0001;
            if (i == 16) v = '0;
            mem[i] = v; init_mem[i] = v; ref_mem[i] = v;
        end
        repeat (2) @(negedge clk);
        fp_reset = 1'b0;

        // single write then read on port 0
        do_reset();
        c0 = commits;
        push(0, 1'b1, 16'h0010, 16'hBEEF, 0);
        push(0, 1'b0, 16'h0010, 16'h0000, 1);
        run_idle("t1_timeout", 40);
        check("t1_acks", 64'(got_lat[0].size()), 64'd2);
        check("t1_wr_latency", 64'(got_lat[0][0]), 64'd2);
        check("t1_rd_latency", 64'(got_lat[0][1]), 64'd2);
        check("t1_we_cycles", 64'(commits - c0), 64'd1);
        check("t1_rdata", 64'(got_rdata[0][1]), 64'h BEEF);

        // both ports hold reads from reset: round-robin alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 16'(16'h0100 + 2 * i), 16'h0, 0);
            push(1, 1'b0, 16'(16'h0180 + 2 * i), 16'h0, 0);
        end
        run_idle("rr_timeout", 60);
        check("rr_acks", 64'(ord_port.size()), 64'd8);
        for (int i = 0; i < 8 && i < ord_port.size(); i++) begin
            check("rr_order", 64'(ord_port[i]), 64'(i % 2));
            if (i > 0) check("rr_spacing", 64'(ord_cyc[i] - ord_cyc[i - 1]), 64'd3);
        end
        for (int i = 0; i < 4 && i < got_rdata[1].size(); i++) begin
            check("rr_p0_data", 64'(got_rdata[0][i]), 64'(init_mem[8'h80 + i]));
            check("rr_p1_data", 64'(got_rdata[1][i]), 64'(init_mem[8'hC0 + i]));
        end

        // write/read conflict on the same word
        do_reset();
        push(1, 1'b1, 16'h0020, 16'h1234, 0);
        push(0, 1'b0, 16'h0020, 16'h0000, 0);
        push(0, 1'b0, 16'h0020, 16'h0000, 0);
        run_idle("cf_timeout", 40);
        check("cf_first_winner", 64'(ord_port[0]), 64'd0);
        check("cf_old_value", 64'(got_rdata[0][0]), 64'h0000);
        check("cf_new_value", 64'(got_rdata[0][1]), 64'h1234);

        // address bit 0 is ignored
        clear_logs();
        push(0, 1'b1, 16'h0041, 16'hAAAA, 0);
        push(0, 1'b0, 16'h0040, 16'h0000, 0);
        run_idle("a0_timeout", 40);
        check("a0_rdata", 64'(got_rdata[0][1]), 64'h AAAA);

        // reset lands during the ACCESS cycle of a write
        do_reset();
        c0 = commits;
        rst_arm = 1'b1;
        push(1, 1'b1, 16'h0030, 16'h5555, 0);
        for (int i = 0; i < 10 && rst_hits == 0; i++) step();
        check("rst_fired", 64'(rst_hits), 64'd1);
        step();
        check("rst_no_ack", 64'(got_lat[1].size()), 64'd0);
        check("rst_no_commit", 64'(commits - c0), 64'd0);
        push(0, 1'b0, 16'h0030, 16'h0000, 0);
        run_idle("rst_timeout", 40);
        check("rst_prior_data", 64'(got_rdata[0][0]), 64'(init_mem[24]));

        // randomized traffic on a small address window to provoke collisions
        clear_logs();
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++)
                push(p, 1'($urandom_range(0, 1)), 16'(16'h0200 + $urandom_range(0, 15)),
                     16'($urandom), $urandom_range(0, 3));
        end
        run_idle("rand_timeout", 2000);
        check("rand_acks_p0", 64'(got_lat[0].size()), 64'd60);
        check("rand_acks_p1", 64'(got_lat[1].size()), 64'd60);
        repeat (2) step();
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", 64'(bad), 64'd0);

        check("fp_p1_acks", 64'(fp_p1_cnt), 64'd0);
        check("fp_p0_active", 64'(fp_p0_cnt > 20), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
